// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The V port exists only when SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_bin;
  logic [WIDTH-1:0] o_diff;
  logic             o_bout;
  logic             o_busy;
  logic             o_done;
`ifdef SUB_OVERFLOW_EN
  logic             o_v;
`endif

`ifdef SUB_OVERFLOW_EN
  modport master (output i_start, i_a, i_b, i_bin,
                  input  o_diff, o_bout, o_busy, o_done, o_v);
  modport slave  (input  i_start, i_a, i_b, i_bin,
                  output o_diff, o_bout, o_busy, o_done, o_v);
`else
  modport master (output i_start, i_a, i_b, i_bin,
                  input  o_diff, o_bout, o_busy, o_done);
  modport slave  (input  i_start, i_a, i_b, i_bin,
                  output o_diff, o_bout, o_busy, o_done);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, LSB first, one bit per clock.
// Optional SUB_OVERFLOW_EN adds a registered two's-complement overflow flag V.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic             r_br;
  logic [WIDTH-1:0] r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
`ifdef SUB_OVERFLOW_EN
  logic             r_v;
`endif

  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_rd_nxt;

  // One full-subtractor slice on the current LSBs
  always_comb begin
    w_d      = r_ra[0] ^ r_rb[0] ^ r_br;
    w_br_nxt = (~r_ra[0] & r_rb[0]) | (~(r_ra[0] ^ r_rb[0]) & r_br);
    w_rd_nxt = {w_d, r_rd[WIDTH-1:1]};
  end

  // Next-state and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.i_start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_br    <= 1'b0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      r_v     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == SHIFT);
      r_done  <= (w_state_nxt == DONE);
      if (w_load) begin
        r_ra  <= bus.i_a;
        r_rb  <= bus.i_b;
        r_br  <= bus.i_bin;
        r_rd  <= '0;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_ra  <= r_ra >> 1;
        r_rb  <= r_rb >> 1;
        r_br  <= w_br_nxt;
        r_rd  <= w_rd_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Result registers move only on the final shift edge
      if (w_last) begin
        r_diff <= w_rd_nxt;
        r_bout <= w_br_nxt;
`ifdef SUB_OVERFLOW_EN
        r_v    <= r_br ^ w_br_nxt;
`endif
      end
    end
  end

  assign bus.o_diff = r_diff;
  assign bus.o_bout = r_bout;
  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
`ifdef SUB_OVERFLOW_EN
  assign bus.o_v    = r_v;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4) against an arithmetic model.
// Checks V as well when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [W-1:0] m_diff;
  logic         m_bout;
  logic         m_v;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result view of the model compared to the DUT outputs
  task automatic chk_result(input string tag);
    chk({tag, ".diff"}, 32'(bus.o_diff), 32'(m_diff));
    chk({tag, ".bout"}, 32'(bus.o_bout), 32'(m_bout));
`ifdef SUB_OVERFLOW_EN
    chk({tag, ".v"}, 32'(bus.o_v), 32'(m_v));
`endif
  endtask

  // Plain-integer reference: unsigned difference, borrow, signed overflow
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int ua, ub, ui, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    ui = int'(bin);
    m_diff = W'((ua - ub - ui + 64) % 16);
    m_bout = (ua < ub + ui);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    sr = sa - sb - ui;
    m_v = (sr < -8) || (sr > 7);
  endtask

  // Called at posedge+1 with the DUT in IDLE or DONE; returns in the DONE cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit inject, input bit hold, input string tag);
    bus.i_start = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_bin   = bin;
    @(posedge clk); #1;
    if (!hold) bus.i_start = 1'b0;
    bus.i_a   = W'($urandom);
    bus.i_b   = W'($urandom);
    bus.i_bin = 1'($urandom);
    for (int c = 0; c < int'(W); c++) begin
      if (inject && c == 1) begin
        bus.i_start = 1'b1;
        bus.i_a     = 4'd1;
        bus.i_b     = 4'd1;
      end else if (inject && c == 2 && !hold) begin
        bus.i_start = 1'b0;
      end
      chk({tag, ".busy"}, 32'(bus.o_busy), 32'd1);
      chk({tag, ".done_low"}, 32'(bus.o_done), 32'd0);
      chk_result({tag, ".hold"});
      @(posedge clk); #1;
    end
    model(a, b, bin);
    chk({tag, ".done"}, 32'(bus.o_done), 32'd1);
    chk({tag, ".busy_low"}, 32'(bus.o_busy), 32'd0);
    chk_result(tag);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    chk({tag, ".done"}, 32'(bus.o_done), 32'd0);
    chk({tag, ".busy"}, 32'(bus.o_busy), 32'd0);
    chk_result(tag);
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_bin   = 1'b0;
    m_diff = '0;
    m_bout = 1'b0;
    m_v    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.done", 32'(bus.o_done), 32'd0);
    chk("reset.busy", 32'(bus.o_busy), 32'd0);
    chk_result("reset");
    rst = 1'b0;
    idle_cycle("idle0");

    run_op(4'd9, 4'd3, 1'b0, 1'b0, 1'b0, "op9m3");
    idle_cycle("after9m3");

    // Asynchronous reset between edges while idle
    #2 rst = 1'b1;
    #1;
    m_diff = '0; m_bout = 1'b0; m_v = 1'b0;
    chk("areset.busy", 32'(bus.o_busy), 32'd0);
    chk("areset.done", 32'(bus.o_done), 32'd0);
    chk_result("areset");
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run_op(4'd3, 4'd9, 1'b0, 1'b0, 1'b0, "op3m9");
    idle_cycle("after3m9");
    run_op(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "op0m0b");
    idle_cycle("after0m0b");

    run_op(4'd12, 4'd5, 1'b0, 1'b1, 1'b0, "inject");
    idle_cycle("inject.single");
    idle_cycle("inject.idle");

    // Reset just after edge 2 abandons the operation
    bus.i_start = 1'b1; bus.i_a = 4'd14; bus.i_b = 4'd1; bus.i_bin = 1'b0;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    m_diff = '0; m_bout = 1'b0; m_v = 1'b0;
    chk("midreset.busy", 32'(bus.o_busy), 32'd0);
    chk("midreset.done", 32'(bus.o_done), 32'd0);
    chk_result("midreset");
    repeat (2) @(posedge clk);
    #1;
    chk("midreset.nodone", 32'(bus.o_done), 32'd0);
    rst = 1'b0;
    idle_cycle("midreset.idle");
    run_op(4'd5, 4'd2, 1'b0, 1'b0, 1'b0, "op5m2");
    idle_cycle("after5m2");

    run_op(4'd8, 4'd1, 1'b0, 1'b0, 1'b0, "ovf8m1");
    idle_cycle("afterovf");
    run_op(4'd5, 4'd2, 1'b0, 1'b0, 1'b0, "novf5m2");
    idle_cycle("afternovf");

    // Start held high: back-to-back operations every W+1 cycles
    run_op(4'd7, 4'd10, 1'b1, 1'b0, 1'b1, "b2b0");
    run_op(4'd15, 4'd15, 1'b1, 1'b0, 1'b1, "b2b1");
    run_op(4'd2, 4'd4, 1'b0, 1'b0, 1'b0, "b2b2");
    idle_cycle("afterb2b");

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      logic rbin;
      bit b2b;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      b2b  = 1'($urandom);
      run_op(ra, rb, rbin, 1'($urandom), b2b, "rand");
      if (!b2b) idle_cycle("rand.idle");
    end
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    idle_cycle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
